ps2_keypad_rx: RTL
==================

Name: ps2_keypad_rx

Overview:
- Receives raw PS/2 keyboard traffic (device-to-host only, scan code set 2) and frames 11-bit packets.
- Tracks make/break (F0) and extended (E0) prefixes, and maps keypad digit and arrow keys to a 4-bit key code.
- Drives the paddle-control stage's tx_start/Data inputs directly: tx_start is a level that is high while the most recently pressed mapped key is held.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before ps2_clk changes its filtered value.
- TIMEOUT_CYCLES, 50000: idle clk cycles with no filtered ps2_clk falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- tx_start  output  1  high while the latched mapped key is held.
- Data  output  4  key code of the latched key.
- frame_err  output  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Reset (async, rst_n=0):
  - tx_start=0, Data=0, frame_err=0.
  - Prefix flags cleared; frame FSM in IDLE.
  - Synchronisers preset to 1 (bus idle-high).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk then passes through a FILTER_LEN-sample stability filter.
  - A falling edge of the filtered clock is the sample strobe; ps2_data is sampled on that strobe.
- Frame FSM:
  - IDLE: on a strobe with data=0 (start bit), go to DATA with bit count 0. A strobe with data=1 stays in IDLE and raises no error.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: require stop=1 and odd parity over the 8 data bits plus the parity bit.
    - Pass: assert internal byte_done for one cycle.
    - Fail: pulse frame_err and discard the byte.
    - Either way, return to IDLE.
  - Timeout: in DATA, PARITY or STOP, if TIMEOUT_CYCLES elapse without a strobe, pulse frame_err, go to IDLE, and leave the prefix flags unchanged.
- Byte handling (on byte_done):
  - E0: set ext flag.
  - F0: set brk flag.
  - Any other byte is a key code. Apply the map, then clear both flags in the same cycle.
- Key map; the ext flag is ignored for mapping, so arrows alias keypad keys:
  - 70→0, 69→1, 72→2, 7A→3, 6B→4 (KP4/left arrow), 73→5, 74→6 (KP6/right arrow), 6C→7, 75→8, 7D→9.
  - Unmapped codes (including E0 12 fake-shift) change nothing.
- Make of a mapped key (brk=0): Data←code, tx_start←1. Typematic repeats of the same key are idempotent.
- Make of a different mapped key while one is held: Data switches to the new code and tx_start stays 1 (last-pressed wins).
- Break of a mapped key (brk=1):
  - If its code equals Data and tx_start=1, tx_start←0 and Data holds its value.
  - Otherwise ignore (e.g. release of an earlier, superseded key).
- Bytes AA, FA, EE, FE and 00/FF are treated as unmapped key codes: they clear the flags and cause no output change.
- Latency:
  - tx_start and Data update in the cycle after byte_done.
  - That is at most FILTER_LEN+5 clk cycles after the raw ps2_clk falling edge that carries the stop bit.
  - Both are registered and glitch-free, and they change in the same cycle.
- frame_err occurs only in the cycle of the failing STOP check or the timeout expiry.
- Reset mid-frame: the partial frame is dropped; the next start bit begins a fresh frame.

Test Plan:
- Reset then idle bus: hold rst_n=0 for 3 cycles with ps2_clk=ps2_data=1, then release → tx_start=0, Data=0, frame_err=0 for 10000 cycles.
- Keypad make/break: send 74 (bit period 80 µs) → tx_start=1, Data=6 within FILTER_LEN+5 cycles of the stop edge. Send F0 74 → tx_start=0, Data stays 6.
- Arrow and last-wins: send E0 6B → Data=4, tx_start=1. Send 69 → Data=1, tx_start=1. Send F0 6B → no change. Send F0 69 → tx_start=0.
- Parity error: send 74 with even parity → frame_err pulses exactly 1 cycle, tx_start stays 0. A following good 73 → Data=5, tx_start=1.
- Timeout: stop ps2_clk after 5 bits of a frame → frame_err pulse TIMEOUT_CYCLES after the last edge. A following full 6B frame decodes to Data=4.
- Glitch/reset: inject 1-cycle ps2_clk low pulses (< FILTER_LEN) → no bit shifted. Assert rst_n mid-frame → outputs go to 0 immediately, and a following 7D → Data=9.

Source files
------------

// File: rtl/ps2_keypad_rx.sv
// PS/2 set-2 receiver: frames 11-bit device-to-host packets, tracks E0/F0 prefixes,
// and maps keypad digit/arrow keys onto a held-key level (tx_start) plus 4-bit code (Data).
module ps2_keypad_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       tx_start,
  output logic [3:0] Data,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic [1:0]     clk_sync_q, data_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe;
  logic           data_s;

  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           byte_done_q, byte_done_d;
  logic           err_q, err_d;

  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic           tx_q, tx_d;
  logic [3:0]     key_q, key_d;
  logic [4:0]     map_hit;

  assign data_s = data_sync_q[1];

  // Idle-high preset so a reset never looks like a falling ps2_clk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values; blocking here would collapse the 2-FF synchroniser into one.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
    end
  end

  always_comb begin
    // NOTE: every combinationally-assigned signal gets a default first; a path that
    // leaves one unassigned would infer a latch.
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                                fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign strobe = filt_q & ~filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      timer_q     <= '0;
      byte_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      timer_q     <= timer_d;
      byte_done_q <= byte_done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    timer_d     = '0;
    byte_done_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe && !data_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (strobe) begin
          par_d   = data_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          if (data_s && (^{shift_q, par_q})) byte_done_d = 1'b1;
          else                               err_d       = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Mid-frame watchdog; a strobe restarts it, so it only fires on a stalled bus.
    if (state_q != S_IDLE && !strobe) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Returns {hit, code}; E0 is not consulted, so arrows alias their keypad keys.
  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h70:   map_key = 5'h10;
      8'h69:   map_key = 5'h11;
      8'h72:   map_key = 5'h12;
      8'h7A:   map_key = 5'h13;
      8'h6B:   map_key = 5'h14;
      8'h73:   map_key = 5'h15;
      8'h74:   map_key = 5'h16;
      8'h6C:   map_key = 5'h17;
      8'h75:   map_key = 5'h18;
      8'h7D:   map_key = 5'h19;
      default: map_key = 5'h00;
    endcase
  endfunction

  assign map_hit = map_key(shift_q);

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    tx_d  = tx_q;
    key_d = key_q;
    if (byte_done_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (map_hit[4]) begin
          if (!brk_q) begin
            tx_d  = 1'b1;
            key_d = map_hit[3:0];
          end else if (tx_q && map_hit[3:0] == key_q) begin
            tx_d = 1'b0;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      tx_q  <= 1'b0;
      key_q <= '0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      tx_q  <= tx_d;
      key_q <= key_d;
    end
  end

  assign tx_start  = tx_q;
  assign Data      = key_q;
  assign frame_err = err_q;

endmodule
